// File: rtl/fc_window_gate.sv
`timescale 1ns/1ps
// fc_window_gate
// Source-side pacing of a CHDR packet stream against a downstream
// flow-control window. Packets are admitted only at packet boundaries and
// only while fewer than 'window' packets are in flight. The in-flight count
// is sent_count - consumed_count (mod 2^32); consumed_count advances from
// the flow-control ACK packets returned by the far-end responder.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   clear               synchronous soft clear (same effect as reset)
//   set_stb/addr/data   settings bus; SR_FC_WINDOW holds
//                       {enable, 15'reserved, window[15:0]}
//   i_t*                source CHDR stream (64-bit)
//   o_t*                gated CHDR stream, zero-latency pass-through
//   fc_t*               returning flow-control packets, always accepted
//   window_full         gating enabled and in_flight >= window
//   in_flight           sent_count - consumed_count
//   fc_err              one-cycle pulse when an ACK sequence is rejected
module fc_window_gate #(
  parameter logic [7:0] SR_FC_WINDOW = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  input  logic [63:0] fc_tdata,
  input  logic        fc_tlast,
  input  logic        fc_tvalid,
  output logic        fc_tready,
  output logic        window_full,
  output logic [31:0] in_flight,
  output logic        fc_err
);

  typedef enum logic [0:0] {G_IDLE = 1'b0, G_PASS = 1'b1} gate_state_t;
  typedef enum logic [1:0] {F_HDR = 2'd0, F_TIME = 2'd1, F_PAY = 2'd2, F_DUMP = 2'd3} fc_state_t;

  gate_state_t gate_q, gate_d;
  fc_state_t   fc_q, fc_d;
  logic        enable_q, enable_d;
  logic [15:0] window_q, window_d;
  logic [31:0] sent_count_q, sent_count_d;
  logic [31:0] consumed_count_q, consumed_count_d;
  logic        fc_err_q, fc_err_d;

  logic [31:0] in_flight_s;
  logic        go_s;
  logic        out_hs_s;
  logic [31:0] fc_new_s;
  logic [31:0] fc_ahead_s;
  logic [31:0] fc_behind_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{fc_tdata[60:32], set_data[30:16]};

  // Data and last are pure pass-through; only valid/ready are gated.
  assign o_tdata     = i_tdata;
  assign o_tlast     = i_tlast;
  assign fc_tready   = ~reset;
  assign fc_err      = fc_err_q;
  assign in_flight   = in_flight_s;

  // Window decision from registered counts: an ACK landing this cycle is
  // only seen by the gate on the following cycle.
  assign in_flight_s = sent_count_q - consumed_count_q;
  assign go_s        = ~enable_q | (in_flight_s < {16'd0, window_q});
  assign window_full = enable_q & (in_flight_s >= {16'd0, window_q});

  // Window register: a write becomes visible the cycle after set_stb.
  always_comb begin
    enable_d = enable_q;
    window_d = window_q;
    if (set_stb && (set_addr == SR_FC_WINDOW)) begin
      enable_d = set_data[31];
      window_d = set_data[15:0];
    end else begin
      enable_d = enable_q;
      window_d = window_q;
    end
  end

  // Gate FSM: the window is consulted only when a new packet would start.
  always_comb begin
    gate_d   = gate_q;
    o_tvalid = 1'b0;
    i_tready = 1'b0;
    case (gate_q)
      G_IDLE: begin
        o_tvalid = i_tvalid & go_s;
        i_tready = o_tready & go_s;
        if (i_tvalid && go_s && o_tready && !i_tlast) begin
          gate_d = G_PASS;
        end else begin
          gate_d = G_IDLE;
        end
      end
      G_PASS: begin
        o_tvalid = i_tvalid;
        i_tready = o_tready;
        if (i_tvalid && o_tready && i_tlast) begin
          gate_d = G_IDLE;
        end else begin
          gate_d = G_PASS;
        end
      end
      default: begin
        gate_d = G_IDLE;
      end
    endcase
  end

  // Packet counter: one increment per completed output packet.
  always_comb begin
    out_hs_s     = o_tvalid & o_tready;
    sent_count_d = sent_count_q;
    if (out_hs_s && i_tlast) begin
      sent_count_d = sent_count_q + 32'd1;
    end else begin
      sent_count_d = sent_count_q;
    end
  end

  // ACK acceptance arithmetic. The ACK carries the last consumed sequence
  // number, so the new consumed count is seq + 1. It must move forward
  // (by less than half the sequence space) and must not pass sent_count.
  always_comb begin
    fc_new_s    = fc_tdata[31:0] + 32'd1;
    fc_ahead_s  = fc_new_s - consumed_count_q;
    fc_behind_s = sent_count_q - fc_new_s;
  end

  // FC parser FSM. has_time is consumed directly from the header word to
  // pick the next state, so it needs no storage of its own.
  always_comb begin
    fc_d             = fc_q;
    consumed_count_d = consumed_count_q;
    fc_err_d         = 1'b0;
    case (fc_q)
      F_HDR: begin
        if (fc_tvalid) begin
          if (fc_tdata[63:62] == 2'b01) begin
            if (fc_tlast) begin
              fc_d = F_HDR;
            end else if (fc_tdata[61]) begin
              fc_d = F_TIME;
            end else begin
              fc_d = F_PAY;
            end
          end else begin
            fc_d = fc_tlast ? F_HDR : F_DUMP;
          end
        end else begin
          fc_d = F_HDR;
        end
      end
      F_TIME: begin
        if (fc_tvalid) begin
          fc_d = fc_tlast ? F_HDR : F_PAY;
        end else begin
          fc_d = F_TIME;
        end
      end
      F_PAY: begin
        if (fc_tvalid) begin
          if ((fc_ahead_s != 32'd0) && !fc_ahead_s[31] && !fc_behind_s[31]) begin
            consumed_count_d = fc_new_s;
          end else if (fc_ahead_s != 32'd0) begin
            fc_err_d = 1'b1;
          end else begin
            // Duplicate ACK: silently ignored.
            fc_err_d = 1'b0;
          end
          fc_d = fc_tlast ? F_HDR : F_DUMP;
        end else begin
          fc_d = F_PAY;
        end
      end
      F_DUMP: begin
        if (fc_tvalid && fc_tlast) begin
          fc_d = F_HDR;
        end else begin
          fc_d = F_DUMP;
        end
      end
      default: begin
        fc_d = F_HDR;
      end
    endcase
  end

  // State registers; reset and clear are equivalent.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      gate_q           <= G_IDLE;
      fc_q             <= F_HDR;
      enable_q         <= 1'b0;
      window_q         <= 16'd0;
      sent_count_q     <= 32'd0;
      consumed_count_q <= 32'd0;
      fc_err_q         <= 1'b0;
    end else begin
      gate_q           <= gate_d;
      fc_q             <= fc_d;
      enable_q         <= enable_d;
      window_q         <= window_d;
      sent_count_q     <= sent_count_d;
      consumed_count_q <= consumed_count_d;
      fc_err_q         <= fc_err_d;
    end
  end

endmodule

// File: tb/tb_fc_window_gate.sv
`timescale 1ns/1ps
module tb_fc_window_gate;

  localparam logic [7:0]  SR  = 8'h10;
  localparam logic [31:0] PRE = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [63:0] i_tdata = 64'd0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic [63:0] fc_tdata = 64'd0;
  logic        fc_tlast = 1'b0;
  logic        fc_tvalid = 1'b0;
  logic        fc_tready;
  logic        window_full;
  logic [31:0] in_flight;
  logic        fc_err;

  fc_window_gate #(.SR_FC_WINDOW(SR)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .fc_tdata(fc_tdata), .fc_tlast(fc_tlast), .fc_tvalid(fc_tvalid), .fc_tready(fc_tready),
    .window_full(window_full), .in_flight(in_flight), .fc_err(fc_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_pulses = 0;
  logic [31:0] max_if = 32'd0;
  logic chk_en = 1'b0;
  logic track_max = 1'b0;
  logic m_preload = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packet-level view: how many words of the current output packet have gone,
  // how far into the current fc packet we are, and the two packet counts.
  logic [31:0] m_sent, m_cons;
  logic        m_en;
  logic [15:0] m_win;
  int          m_out_words = 0;
  int          m_fc_idx = 0;
  logic        m_fc_ok, m_fc_time, m_err;

  logic [31:0] e_inflight, e_new;
  logic        e_open, e_otvalid, e_itready, e_wfull, e_is_pay, e_accept, e_reject;

  always_comb begin
    e_inflight = m_sent - m_cons;
    e_open     = (m_out_words != 0) || !m_en || (e_inflight < {16'd0, m_win});
    e_otvalid  = i_tvalid && e_open;
    e_itready  = o_tready && e_open;
    e_wfull    = m_en && (e_inflight >= {16'd0, m_win});
    e_new      = fc_tdata[31:0] + 32'd1;
    e_is_pay   = fc_tvalid && m_fc_ok && (m_fc_idx == (m_fc_time ? 2 : 1));
    e_accept   = e_is_pay && ($signed(e_new - m_cons) > 0) && ($signed(m_sent - e_new) >= 0);
    e_reject   = e_is_pay && !e_accept && (e_new != m_cons);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || clear) begin
      m_sent <= 32'd0; m_cons <= 32'd0; m_en <= 1'b0; m_win <= 16'd0;
      m_out_words <= 0; m_fc_idx <= 0; m_fc_ok <= 1'b0; m_fc_time <= 1'b0; m_err <= 1'b0;
    end else if (m_preload) begin
      m_sent <= PRE; m_cons <= PRE; m_err <= 1'b0;
    end else begin
      if (set_stb && set_addr == SR) begin
        m_en <= set_data[31]; m_win <= set_data[15:0];
      end
      if (e_otvalid && o_tready) begin
        if (i_tlast) begin
          m_out_words <= 0; m_sent <= m_sent + 32'd1;
        end else begin
          m_out_words <= m_out_words + 1;
        end
      end
      if (fc_tvalid) begin
        m_fc_idx <= fc_tlast ? 0 : m_fc_idx + 1;
        if (m_fc_idx == 0) begin
          m_fc_ok <= (fc_tdata[63:62] == 2'b01); m_fc_time <= fc_tdata[61];
        end
      end
      if (e_accept) m_cons <= e_new;
      m_err <= e_reject;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_tvalid", o_tvalid, e_otvalid);
      check("i_tready", i_tready, e_itready);
      check("o_tdata", o_tdata, i_tdata);
      check("o_tlast", o_tlast, i_tlast);
      check("window_full", window_full, e_wfull);
      check("in_flight", in_flight, e_inflight);
      check("fc_err", fc_err, m_err);
      check("fc_tready", fc_tready, !reset);
      if (fc_err) err_pulses <= err_pulses + 1;
    end
    if (!track_max) max_if <= 32'd0;
    else if (in_flight > max_if) max_if <= in_flight;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_win(input logic [7:0] addr, input logic [31:0] data);
    set_stb = 1'b1; set_addr = addr; set_data = data;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [63:0] base, input int budget,
                          output bit ok, output int first_hs);
    int waited;
    ok = 1'b1; first_hs = -1;
    for (int w = 0; w < n && ok; w++) begin
      i_tvalid = 1'b1; i_tdata = base + 64'(w); i_tlast = (w == n - 1);
      waited = 0;
      @(negedge clk);
      while (!i_tready && waited < budget) begin
        @(negedge clk); waited++;
      end
      if (!i_tready) ok = 1'b0;
      else if (w == 0) first_hs = cyc + 1;
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic send_fc(input int n, input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [63:0] w3,
                         input int pay_idx, output int pay_cyc);
    logic [63:0] words [4];
    words = '{w0, w1, w2, w3};
    pay_cyc = -1;
    for (int w = 0; w < n; w++) begin
      fc_tvalid = 1'b1; fc_tdata = words[w]; fc_tlast = (w == n - 1);
      if (w == pay_idx) pay_cyc = cyc + 1;
      tick();
    end
    fc_tvalid = 1'b0; fc_tlast = 1'b0;
  endtask

  localparam logic [63:0] HDR_FC   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] HDR_FC_T = 64'h6000_0000_0000_0000;
  localparam logic [63:0] HDR_DATA = 64'h0000_0000_0000_0000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok, ok_a, ok_c;
    int hs, hs_a, payc, c0;

    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_in_flight", in_flight, 32'd0);
    check("rst_window_full", window_full, 1'b0);
    check("rst_fc_err", fc_err, 1'b0);

    // Wrong address is ignored, gating stays disabled.
    set_win(8'h11, 32'h8000_0000);
    c0 = cyc;
    for (int p = 0; p < 10; p++) begin
      send_pkt(4, 64'h1000 + 64'(p * 16), 4, ok, hs);
      check($sformatf("t1_pkt%0d", p), ok, 1'b1);
    end
    check("t1_cycles", cyc - c0, 40);
    check("t1_in_flight", in_flight, 32'd10);
    check("t1_window_full", window_full, 1'b0);

    // Drain to zero in flight, then window = 3.
    send_fc(2, HDR_FC, 64'd9, 0, 0, 1, payc);
    check("t1_drained", in_flight, 32'd0);
    set_win(SR, 32'h8000_0003);
    for (int p = 0; p < 3; p++) begin
      send_pkt(4, 64'h2000 + 64'(p * 16), 4, ok, hs);
      check($sformatf("t2_pkt%0d", p), ok, 1'b1);
    end
    send_pkt(4, 64'h2100, 5, ok, hs);
    check("t2_blocked", ok, 1'b0);
    check("t2_window_full", window_full, 1'b1);
    check("t2_in_flight", in_flight, 32'd3);

    // ACK seq 10 frees one slot; the 4th packet follows the payload by one cycle.
    fork
      send_pkt(4, 64'h3000, 20, ok_a, hs_a);
      begin
        send_fc(2, HDR_FC, 64'd10, 0, 0, 1, payc);
        @(negedge clk);
        check("t3_in_flight_after_ack", in_flight, 32'd2);
      end
    join
    check("t3_released", ok_a, 1'b1);
    check("t3_release_delay", 32'(hs_a - payc), 32'd1);
    check("t3_in_flight", in_flight, 32'd3);

    // ACK with timestamp word, seq 12 -> consumed 13.
    send_fc(3, HDR_FC_T, 64'hDEAD_BEEF, 64'd12, 0, 2, payc);
    check("t4_in_flight", in_flight, 32'd1);
    send_pkt(2, 64'h4000, 4, ok, hs);
    check("t4_pkt", ok, 1'b1);
    send_fc(3, HDR_FC, 64'd7, 64'h55, 0, 1, payc);   // behind consumed
    send_fc(2, HDR_FC, 64'd20, 0, 0, 1, payc);       // beyond sent
    send_fc(2, HDR_FC, 64'd12, 0, 0, 1, payc);       // duplicate
    tick();
    check("t4_err_pulses", err_pulses, 2);
    check("t4_in_flight_kept", in_flight, 32'd2);

    // Non-fc packet on the fc port is dumped.
    send_fc(4, HDR_DATA, 64'd13, 64'd13, 64'd13, 1, payc);
    check("t5_dumped", in_flight, 32'd2);
    // Window -> 0 mid-packet: packet completes, next blocked.
    fork
      send_pkt(4, 64'h5000, 5, ok_c, hs);
      begin
        tick(); tick();
        set_win(SR, 32'h8000_0000);
      end
    join
    check("t5_completed", ok_c, 1'b1);
    send_pkt(1, 64'h5100, 5, ok, hs);
    check("t5_blocked", ok, 1'b0);
    check("t5_window_full", window_full, 1'b1);
    check("t5_in_flight", in_flight, 32'd3);

    // Counter wrap: both counts preloaded just below 2^32, window 4.
    set_win(SR, 32'h8000_0004);
    m_preload = 1'b1;
    tick();
    m_preload = 1'b0;
    force dut.sent_count_q = PRE;
    force dut.consumed_count_q = PRE;
    #1;
    release dut.sent_count_q;
    release dut.consumed_count_q;
    tick();
    check("t6_preload", in_flight, 32'd0);
    track_max = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_pkt(1, 64'h6000 + 64'(k), 4, ok, hs);
      check($sformatf("t6_pkt%0d", k), ok, k < 4);
    end
    check("t6_in_flight_full", in_flight, 32'd4);
    send_fc(2, HDR_FC, 64'hFFFF_FFFF, 0, 0, 1, payc);
    check("t6_ack_wrap", in_flight, 32'd2);
    for (int k = 0; k < 3; k++) begin
      send_pkt(1, 64'h6100 + 64'(k), 4, ok, hs);
      check($sformatf("t6_pkt_b%0d", k), ok, k < 2);
    end
    send_fc(2, HDR_FC, 64'd5, 0, 0, 1, payc);
    send_fc(2, HDR_FC, 64'd3, 0, 0, 1, payc);
    tick();
    check("t6_err_pulses", err_pulses, 3);
    check("t6_in_flight_end", in_flight, 32'd0);
    check("t6_max_in_flight", max_if, 32'd4);
    track_max = 1'b0;

    // Soft clear while quiescent.
    send_pkt(1, 64'h7000, 4, ok, hs);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_in_flight", in_flight, 32'd0);
    check("clr_window_full", window_full, 1'b0);
    send_pkt(1, 64'h7100, 4, ok, hs);
    check("clr_pass", ok, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
